// File: rtl/mem_data_responder.sv
// mem_data_responder
// Target side of the MEM-stage load/store interface. Accepts one request at
// a time over a valid/ready handshake, optionally waits a fixed number of
// cycles, performs a single access to a synchronous block-RAM array and
// returns a one-cycle response carrying load data or an address error.

module mem_data_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Req_Valid_MEM,
    output logic        Req_Ready_MEM,
    input  logic        Req_Write_MEM,
    input  logic [31:0] Addr_MEM,
    input  logic [31:0] Write_Data_MEM,
    input  logic [3:0]  Byte_En_MEM,
    output logic        Resp_Valid_MEM,
    output logic [31:0] Read_Data_MEM,
    output logic        Addr_Error_MEM
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    localparam bit         NO_WAIT   = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t                  state;
    logic [3:0]              wait_count;

    // Request captured on the accept edge; used when the access is deferred.
    logic                    lat_write;
    logic [ADDR_WIDTH-1:0]   lat_word;
    logic [31:0]             lat_data;
    logic [3:0]              lat_be;

    // Fields of the access performed on the current edge.
    logic                    accept;
    logic                    addr_bad;
    logic                    access_now;
    logic                    acc_write;
    logic [ADDR_WIDTH-1:0]   acc_word;
    logic [31:0]             acc_data;
    logic [3:0]              acc_be;

    // Storage and response registers.
    logic [31:0]             mem [DEPTH];
    logic [31:0]             mem_rdata;
    logic                    rdata_sel;
    logic                    resp_valid;
    logic                    addr_error;

    // Ready only in IDLE, and forced low while reset is held so nothing is
    // accepted on a reset edge.
    assign Req_Ready_MEM = (state == ST_IDLE) && !Reset;
    assign accept        = Req_Valid_MEM && Req_Ready_MEM;

    // Misaligned addresses and any address bit above the array are rejected.
    assign addr_bad = (Addr_MEM[1:0] != 2'b00) ||
                      ((Addr_MEM >> (ADDR_WIDTH + 2)) != 32'd0);

    // Select between the live request (zero wait states, access on the
    // accept edge) and the latched request (access at the end of WAIT).
    always_comb begin
        access_now = 1'b0;
        acc_write  = lat_write;
        acc_word   = lat_word;
        acc_data   = lat_data;
        acc_be     = lat_be;
        if (state == ST_IDLE) begin
            acc_write  = Req_Write_MEM;
            acc_word   = Addr_MEM[ADDR_WIDTH+1:2];
            acc_data   = Write_Data_MEM;
            acc_be     = Byte_En_MEM;
            access_now = accept && !addr_bad && NO_WAIT;
        end else if (state == ST_WAIT) begin
            access_now = (wait_count == 4'd1) && !Reset;
        end
    end

    // Block-RAM port: byte-lane writes and a registered read. Not reset, so
    // contents survive a reset and committed stores stay in place.
    always_ff @(posedge Clk) begin
        if (access_now) begin
            if (acc_write) begin
                for (int lane = 0; lane < 4; lane++) begin
                    if (acc_be[lane]) begin
                        mem[acc_word][8*lane +: 8] <= acc_data[8*lane +: 8];
                    end
                end
            end else begin
                mem_rdata <= mem[acc_word];
            end
        end
    end

    // Request sequencing: IDLE -> (WAIT) -> RESP -> IDLE, with the response
    // flags loaded on the same edge the state enters RESP.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_IDLE;
            wait_count <= 4'd0;
            resp_valid <= 1'b0;
            addr_error <= 1'b0;
            rdata_sel  <= 1'b0;
            lat_write  <= 1'b0;
            lat_word   <= '0;
            lat_data   <= 32'd0;
            lat_be     <= 4'd0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_write <= Req_Write_MEM;
                        lat_word  <= Addr_MEM[ADDR_WIDTH+1:2];
                        lat_data  <= Write_Data_MEM;
                        lat_be    <= Byte_En_MEM;
                        if (addr_bad) begin
                            addr_error <= 1'b1;
                            rdata_sel  <= 1'b0;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else if (NO_WAIT) begin
                            addr_error <= 1'b0;
                            rdata_sel  <= !Req_Write_MEM;
                            resp_valid <= 1'b1;
                            state      <= ST_RESP;
                        end else begin
                            wait_count <= WAIT_LOAD;
                            state      <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_count <= wait_count - 4'd1;
                    if (wait_count == 4'd1) begin
                        addr_error <= 1'b0;
                        rdata_sel  <= !lat_write;
                        resp_valid <= 1'b1;
                        state      <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load data is only shown after a load; stores and errors read as zero.
    assign Resp_Valid_MEM = resp_valid;
    assign Read_Data_MEM  = rdata_sel ? mem_rdata : 32'd0;
    assign Addr_Error_MEM = addr_error;

endmodule

// File: tb/tb_mem_data_responder.sv
// tb_mem_data_responder
// Self-checking bench: a directed vector table, hand-written multi-cycle
// sequences (back-to-back, reset during WAIT, zero wait states) and a
// randomized run compared against a word-array reference model.

module tb_mem_data_responder;

    localparam int ADDR_WIDTH  = 10;
    localparam int WAIT_STATES = 2;
    localparam int DEPTH       = 1 << ADDR_WIDTH;

    logic        clk;
    logic        reset;

    // Instance with the default two wait states.
    logic        req_valid, req_ready, req_write;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic        resp_valid, addr_err;
    logic [31:0] rdata;

    // Instance with zero wait states.
    logic        z_valid, z_ready, z_write;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_be;
    logic        z_resp, z_err;
    logic [31:0] z_rdata;

    int checks_total  = 0;
    int checks_passed = 0;
    int cyc           = 0;

    logic [31:0] ref_mem [int];

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [16];

    mem_data_responder #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_STATES(WAIT_STATES)) dut (
        .Clk(clk), .Reset(reset),
        .Req_Valid_MEM(req_valid), .Req_Ready_MEM(req_ready),
        .Req_Write_MEM(req_write), .Addr_MEM(addr),
        .Write_Data_MEM(wdata), .Byte_En_MEM(be),
        .Resp_Valid_MEM(resp_valid), .Read_Data_MEM(rdata),
        .Addr_Error_MEM(addr_err)
    );

    mem_data_responder #(.ADDR_WIDTH(ADDR_WIDTH), .WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(reset),
        .Req_Valid_MEM(z_valid), .Req_Ready_MEM(z_ready),
        .Req_Write_MEM(z_write), .Addr_MEM(z_addr),
        .Write_Data_MEM(z_wdata), .Byte_En_MEM(z_be),
        .Resp_Valid_MEM(z_resp), .Read_Data_MEM(z_rdata),
        .Addr_Error_MEM(z_err)
    );

    // 10-unit clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle number; read at the falling edge it names the current cycle.
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop if something hangs beyond every bounded wait.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks_total++;
        if (actual === expected) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    // Reference model: word-indexed array with byte-lane merge.
    function automatic void model_expect(input logic wr, input logic [31:0] a,
                                         output logic err, output logic [31:0] rd,
                                         output bit known);
        err   = (a % 4 != 0) || (a >= 32'(4 * DEPTH));
        rd    = 32'd0;
        known = 1'b1;
        if (!err && !wr) begin
            if (ref_mem.exists(int'(a >> 2))) rd = ref_mem[int'(a >> 2)];
            else known = 1'b0;
        end
    endfunction

    function automatic void model_commit(input logic wr, input logic [31:0] a,
                                         input logic [31:0] d, input logic [3:0] lanes);
        logic [31:0] cur;
        int idx;
        if (!wr || (a % 4 != 0) || (a >= 32'(4 * DEPTH))) return;
        idx = int'(a >> 2);
        if (!ref_mem.exists(idx)) begin
            if (lanes != 4'hF) return;
            cur = 32'd0;
        end else begin
            cur = ref_mem[idx];
        end
        for (int b = 0; b < 4; b++)
            if (lanes[b]) cur[8*b +: 8] = d[8*b +: 8];
        ref_mem[idx] = cur;
    endfunction

    // One full request on the two-wait-state instance. Starts and ends at a
    // falling edge with the responder idle.
    task automatic applyStimulus(input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] lanes,
                                 input logic exp_err, input logic [31:0] exp_rd,
                                 input bit chk_rd, input string tag);
        int acc, waited, exp_lat;
        logic [31:0] held_rd;
        exp_lat   = exp_err ? 1 : WAIT_STATES + 1;
        req_valid = 1'b1;
        req_write = wr;
        addr      = a;
        wdata     = d;
        be        = lanes;
        waited    = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checkOutput({tag, " accept timeout"}, 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = 1'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
        be        = 4'($urandom);
        checkOutput({tag, " ready low after accept"}, 32'(req_ready), 32'd0);
        waited = 1;
        while (!resp_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (!resp_valid) begin
            checkOutput({tag, " response timeout"}, 32'd0, 32'd1);
            return;
        end
        checkOutput({tag, " latency"}, 32'(cyc - acc), 32'(exp_lat));
        checkOutput({tag, " addr_error"}, 32'(addr_err), 32'(exp_err));
        if (chk_rd) checkOutput({tag, " read_data"}, rdata, exp_rd);
        held_rd = rdata;
        @(negedge clk);
        checkOutput({tag, " resp single cycle"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, " read_data hold"}, rdata, held_rd);
        checkOutput({tag, " ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        int acc_c [2];
        int resp_c [2];
        logic [31:0] resp_d [2];
        int n_acc, n_resp;
        bit seen;
        logic e;
        logic [31:0] r;
        bit known;
        logic w;
        logic [31:0] a, d;
        logic [3:0] l;
        int sel;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'h0000_00AA, 4'h1, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA};
        vecs[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 1'b0, 32'hDEAD_BEAA};
        vecs[6]  = '{1'b0, 32'h0000_0012, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[7]  = '{1'b0, 32'h0000_1000, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[8]  = '{1'b1, 32'h0000_0011, 32'h1111_1111, 4'hF, 1'b1, 32'h0};
        vecs[9]  = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEAA};
        vecs[10] = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0};
        vecs[11] = '{1'b1, 32'h0000_0FFC, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0};
        vecs[12] = '{1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 1'b0, 32'hA5A5_A5A5};
        vecs[13] = '{1'b0, 32'h8000_0010, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[14] = '{1'b1, 32'h0000_1010, 32'h0,         4'hF, 1'b1, 32'h0};
        vecs[15] = '{1'b0, 32'h0000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEAA};

        reset     = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
        z_valid   = 1'b0; z_write = 1'b0; z_addr = 32'd0; z_wdata = 32'd0; z_be = 4'd0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 32'(req_ready), 32'd0);
        checkOutput("reset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset read_data", rdata, 32'd0);
        checkOutput("reset addr_error", 32'(addr_err), 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("ready after reset", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Directed vector table.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be,
                          vecs[i].exp_err, vecs[i].exp_rd, 1'b1, $sformatf("vec%0d", i));
            model_commit(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].be);
        end

        // Back-to-back loads with valid held high.
        req_valid = 1'b1; req_write = 1'b0; addr = 32'h10; be = 4'hF;
        n_acc = 0; n_resp = 0;
        for (int i = 0; i < 14; i++) begin
            if (req_valid && req_ready && n_acc < 2) begin acc_c[n_acc] = cyc; n_acc++; end
            if (resp_valid && n_resp < 2) begin
                resp_c[n_resp] = cyc; resp_d[n_resp] = rdata; n_resp++;
            end
            @(negedge clk);
            if (n_acc == 2) req_valid = 1'b0;
        end
        checkOutput("b2b accepts", 32'(n_acc), 32'd2);
        checkOutput("b2b responses", 32'(n_resp), 32'd2);
        if (n_acc == 2 && n_resp == 2) begin
            checkOutput("b2b accept spacing", 32'(acc_c[1] - acc_c[0]), 32'(WAIT_STATES + 2));
            checkOutput("b2b first latency", 32'(resp_c[0] - acc_c[0]), 32'(WAIT_STATES + 1));
            checkOutput("b2b data0", resp_d[0], ref_mem[4]);
            checkOutput("b2b data1", resp_d[1], ref_mem[4]);
        end

        // Reset while a store waits: no commit, no response.
        applyStimulus(1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEAD_BEAA, 1'b1, "pre-reset load");
        req_valid = 1'b1; req_write = 1'b1; addr = 32'h20; wdata = 32'h1234_5678; be = 4'hF;
        checkOutput("midreset accept ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset     = 1'b1;
        @(negedge clk);
        checkOutput("midreset ready", 32'(req_ready), 32'd0);
        checkOutput("midreset resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("midreset read_data", rdata, 32'd0);
        checkOutput("midreset addr_error", 32'(addr_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            seen |= resp_valid;
        end
        checkOutput("midreset no response", 32'(seen), 32'd0);
        applyStimulus(1'b0, 32'h20, 32'h0, 4'hF, 1'b0, 32'h0BAD_F00D, 1'b1, "post-reset load");

        // Zero wait states: store then held loads.
        z_valid = 1'b1; z_write = 1'b1; z_addr = 32'h40; z_wdata = 32'hCAFE_F00D; z_be = 4'hF;
        checkOutput("ws0 ready", 32'(z_ready), 32'd1);
        @(negedge clk);
        z_valid = 1'b0;
        checkOutput("ws0 store resp", 32'(z_resp), 32'd1);
        checkOutput("ws0 store err", 32'(z_err), 32'd0);
        checkOutput("ws0 store data", z_rdata, 32'd0);
        checkOutput("ws0 ready low", 32'(z_ready), 32'd0);
        @(negedge clk);
        checkOutput("ws0 resp single", 32'(z_resp), 32'd0);
        z_valid = 1'b1; z_write = 1'b0;
        n_acc = 0; n_resp = 0;
        for (int i = 0; i < 10; i++) begin
            if (z_valid && z_ready && n_acc < 2) begin acc_c[n_acc] = cyc; n_acc++; end
            if (z_resp && n_resp < 2) begin
                resp_c[n_resp] = cyc; resp_d[n_resp] = z_rdata; n_resp++;
            end
            @(negedge clk);
            if (n_acc == 2) z_valid = 1'b0;
        end
        checkOutput("ws0 accepts", 32'(n_acc), 32'd2);
        checkOutput("ws0 responses", 32'(n_resp), 32'd2);
        if (n_acc == 2 && n_resp == 2) begin
            checkOutput("ws0 accept spacing", 32'(acc_c[1] - acc_c[0]), 32'd2);
            checkOutput("ws0 latency", 32'(resp_c[0] - acc_c[0]), 32'd1);
            checkOutput("ws0 data0", resp_d[0], 32'hCAFE_F00D);
            checkOutput("ws0 data1", resp_d[1], 32'hCAFE_F00D);
        end

        // Preload a pool of words, then random traffic against the model.
        for (int wi = 64; wi < 80; wi++) begin
            d = $urandom;
            applyStimulus(1'b1, 32'(wi * 4), d, 4'hF, 1'b0, 32'h0, 1'b1, "preload");
            model_commit(1'b1, 32'(wi * 4), d, 4'hF);
        end
        for (int i = 0; i < 60; i++) begin
            w   = 1'($urandom_range(0, 1));
            sel = $urandom_range(0, 9);
            if (sel < 7)      a = 32'h100 + 32'(4 * $urandom_range(0, 15));
            else if (sel < 9) a = 32'h100 + 32'($urandom_range(0, 63));
            else              a = $urandom;
            d = $urandom;
            l = 4'($urandom_range(0, 15));
            model_expect(w, a, e, r, known);
            applyStimulus(w, a, d, l, e, r, known, $sformatf("rand%0d", i));
            model_commit(w, a, d, l);
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
